data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: a multi-cycle load/store slave with valid/ready handshakes.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_align.sv | 48 ++++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access sizes and FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store data/byte-enables and load extraction with extension.
module mem_align
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size,
    input  logic [1:0]    lane,
    input  logic          is_unsigned,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rword,
    output logic [3:0]    be,
    output logic [DW-1:0] wlanes,
    output logic [DW-1:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be     = 4'b0000;
        wlanes = '0;
        rdata  = '0;
        rbyte  = rword[lane*8 +: 8];
        rhalf  = lane[1] ? rword[31:16] : rword[15:0];
        unique case (size)
            SZ_BYTE: begin
                be     = 4'b0001 << lane;
                wlanes = {4{wdata[7:0]}};
                rdata  = is_unsigned ? {{(DW-8){1'b0}}, rbyte}
                                     : {{(DW-8){rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
                rdata  = is_unsigned ? {{(DW-16){1'b0}}, rhalf}
                                     : {{(DW-16){rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                be     = 4'b1111;
                wlanes = wdata;
                rdata  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store slave: accepts one request, commits after LATENCY cycles, holds the response until consumed.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 17,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [7:0]    mem [2**AW];

    resp_state_e   state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic          we_q, uns_q, err_q;
    logic [1:0]    size_q;
    logic [DW-1:0] wdata_q;

    logic          accept, commit, req_err;
    logic [DW-1:0] rword, ld_data, wlanes;
    logic [3:0]    be;

    assign req_ready_o = (state == IDLE) && rst;
    assign accept      = req_valid_i && req_ready_o;
    assign commit      = (state == WAIT) && (cnt == '0);

    // Out of range means any address bit at or above AW is set.
    assign req_err = (req_size_i == 2'd3)
                   || (req_size_i == SZ_HALF && req_addr_i[0])
                   || (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00)
                   || (|req_addr_i[DW-1:AW]);

    assign rword = {mem[{addr_q[AW-1:2], 2'd3}], mem[{addr_q[AW-1:2], 2'd2}],
                    mem[{addr_q[AW-1:2], 2'd1}], mem[{addr_q[AW-1:2], 2'd0}]};

    mem_align #(.DW(DW)) u_align (
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rword       (rword),
        .be          (be),
        .wlanes      (wlanes),
        .rdata       (ld_data)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    if (rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'd0;
            wdata_q     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr_i[AW-1:0];
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                size_q  <= req_size_i;
                wdata_q <= req_wdata_i;
                err_q   <= req_err;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= err_q;
                rsp_rdata_o <= (we_q || err_q) ? '0 : ld_data;
            end else if (state == RESP && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_err_o   <= 1'b0;
                rsp_rdata_o <= '0;
            end
        end
    end

    // NOTE: the array has no reset; contents survive rst, and reset only blocks the commit by forcing IDLE.
    always_ff @(posedge clk) begin
        if (commit && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[{addr_q[AW-1:2], 2'(i)}] <= wlanes[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expected values.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;

    int n_cmp = 0;
    int n_mis = 0;

    data_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o)
    );

    always #5 clk = ~clk;

    // Drives one request, waits (bounded) for the response, then consumes it. lat = -1 on timeout.
    task automatic transact(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_wdata_i = 32'hA5A5A5A5; req_addr_i = 32'h0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid_o) begin lat = c; break; end
        end
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== 35'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got rdy=%b v=%b e=%b d=%h, want all 0",
                     req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_mis++; $display("FAIL ready_after_reset: got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_word_store_load;
        logic [31:0] d; logic e; int lat;
        transact(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, d, e, lat);
        n_cmp++;
        if (lat !== 2 || d !== 32'h0 || e !== 1'b0) begin
            n_mis++; $display("FAIL store_word: got lat=%0d d=%h e=%b want lat=2 d=0 e=0", lat, d, e);
        end
        transact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, d, e, lat);
        n_cmp++;
        if (lat !== 2 || d !== 32'hDEADBEEF || e !== 1'b0) begin
            n_mis++; $display("FAIL load_word: got lat=%0d d=%h e=%b want lat=2 d=deadbeef e=0", lat, d, e);
        end
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_mis++; $display("FAIL idle_after_handshake: got rdy=%b want 1", req_ready_o);
        end
    endtask

    task automatic test_sub_word_loads;
        logic [31:0] d; logic e; int lat;
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad  [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            transact(1'b0, sz[i], un[i], ad[i], 32'h0, d, e, lat);
            n_cmp++;
            if (d !== exp[i] || e !== 1'b0 || lat !== 2) begin
                n_mis++;
                $display("FAIL subword_load_%0d: got d=%h e=%b lat=%0d want d=%h e=0 lat=2",
                         i, d, e, lat, exp[i]);
            end
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] d; logic e; int lat;
        transact(1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF55, d, e, lat);
        transact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, d, e, lat);
        n_cmp++;
        if (d !== 32'hDEAD55EF || e !== 1'b0) begin
            n_mis++; $display("FAIL byte_store: got d=%h e=%b want dead55ef e=0", d, e);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int lat;
        transact(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, d, e, lat);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1 || lat !== 2) begin
            n_mis++; $display("FAIL err_misaligned_word: got d=%h e=%b lat=%0d want 0 1 2", d, e, lat);
        end
        transact(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, d, e, lat);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_mis++; $display("FAIL err_misaligned_half_store: got d=%h e=%b want 0 1", d, e);
        end
        transact(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, d, e, lat);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_mis++; $display("FAIL err_size3: got d=%h e=%b want 0 1", d, e);
        end
        transact(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0, d, e, lat);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_mis++; $display("FAIL err_out_of_range: got d=%h e=%b want 0 1", d, e);
        end
        transact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, d, e, lat);
        n_cmp++;
        if (d !== 32'hDEAD55EF || e !== 1'b0) begin
            n_mis++; $display("FAIL err_no_write: got d=%h e=%b want dead55ef 0", d, e);
        end
    endtask

    task automatic test_backpressure;
        int lat = -1;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd0;
        req_unsigned_i = 1'b1; req_addr_i = 32'h103;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid_o) begin lat = c; break; end
        end
        n_cmp++;
        if (lat !== 2) begin
            n_mis++; $display("FAIL bp_latency: got %0d want 2", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid_i = c[0] ? 1'b0 : 1'b1;
            req_we_i = 1'b1; req_size_i = 2'd2; req_addr_i = 32'h100 + 32'(4 * c);
            req_wdata_i = 32'h1111_0000 + 32'(c);
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h000000DE ||
                rsp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin
                n_mis++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h e=%b rdy=%b want 1 000000de 0 0",
                         c, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
            end
        end
        @(negedge clk);
        req_valid_i = 1'b0; req_we_i = 1'b0; rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        n_cmp++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_mis++;
            $display("FAIL bp_release: got v=%b d=%h e=%b rdy=%b want 0 0 0 1",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_mis++; $display("FAIL bp_no_extra_accept: got v=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] d; logic e; int lat;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2;
        req_unsigned_i = 1'b0; req_addr_i = 32'h100; req_wdata_i = 32'h0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== 35'd0) begin
            n_mis++;
            $display("FAIL midreset_outputs: got rdy=%b v=%b e=%b d=%h want all 0",
                     req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        transact(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, d, e, lat);
        n_cmp++;
        if (d !== 32'hDEAD55EF || e !== 1'b0 || lat !== 2) begin
            n_mis++; $display("FAIL midreset_no_commit: got d=%h e=%b lat=%0d want dead55ef 0 2", d, e, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_sub_word_loads();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
